irq_pending_latch_4ch: RTL
==========================

Name: irq_pending_latch_4ch

Overview:
- Upstream stage of the 4-to-2 priority encoder.
- Converts four raw, level-style request lines into latched pending flags. The flags drive the encoder's 4-bit request input.
- Pending flags are held until the consumer acknowledges the encoded channel ID, which is the encoder's 2-bit output returned with an ack strobe.
- Also provides per-channel enable masking, a summary interrupt and sticky overflow flags.

Parameters:
- N_REQ, 4, number of request channels; fixed at 4 in this revision to match the encoder.
- ID_W, 2, width of the acknowledge channel ID; equals clog2(N_REQ).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- req_in  input  N_REQ  raw request lines; a rising edge marks an event
- en_mask  input  N_REQ  per-channel enable; 1 = channel forwarded on pend
- ack  input  1  single-cycle acknowledge strobe from the consumer
- ack_id  input  ID_W  channel being acknowledged; valid only when ack=1
- clr_ovf  input  1  single-cycle strobe that clears all overflow flags
- pend  output  N_REQ  pending & en_mask; connects to the encoder request input I
- irq  output  1  OR-reduction of pend
- overflow  output  N_REQ  sticky per-channel flag: an event arrived while that channel was already pending

Behaviour:
- Reset (async, rst=1):
  - pending, overflow and req_prev all clear to 0.
  - pend=0, irq=0 immediately, without waiting for a clock edge.
  - All flops use asynchronous active-high reset.
- Edge detect, per channel i:
  - evt[i] = req_in_s[i] & ~req_prev[i].
  - req_prev is updated with req_in_s every clock.
  - req_in_s is req_in directly, or its synchronized copy when the optional feature is enabled.
- Pending register, per channel i, evaluated each rising clk:
  - If evt[i]=1: pending[i] is set to 1. This applies even if ack targets i in the same cycle; set wins, so the new event is never lost.
  - Else if ack=1 and ack_id==i: pending[i] is cleared to 0.
  - Otherwise pending[i] holds.
- Overflow, per channel i:
  - Set when evt[i]=1 and pending[i]=1 and not (ack=1 & ack_id==i) in the same cycle.
  - Sticky until clr_ovf=1 or reset.
  - If clr_ovf and a new overflow occur in the same cycle, set wins.
- Masking:
  - en_mask gates only the pend output.
  - Masked channels still latch events and overflows.
  - Unmasking a channel exposes its held pending bit combinationally, in the same cycle.
- Outputs:
  - pend and irq are combinational from registered state and en_mask. No logic from req_in reaches them combinationally.
- Latency (optional feature off):
  - A req_in rise sampled at edge k (low at edge k-1) gives pending=1 after edge k.
  - pend and irq are high during cycle k+1.
- Ack:
  - An ack to a non-pending channel has no effect and raises no error.
  - The ack is accepted on every clock; there is no backpressure.
- Level-held requests:
  - A request held high generates exactly one event. It must fall and rise again to re-trigger.
- Reset mid-operation:
  - All pending and overflow state is discarded.
  - A req_in that is high when rst deasserts does NOT produce an event, because req_prev is reloaded with req_in_s on the first clock after reset.
  - To implement this, a one-cycle post-reset flag blocks evt for that cycle.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined:
  - req_in passes through a 2-flop synchronizer per channel before edge detect; flops reset to 0.
  - Latency becomes req rise to pend high in 3 cycles.
  - The post-reset event block extends until the synchronizer is filled: 3 cycles after reset release.
- Undefined:
  - req_in feeds edge detect directly.
  - Requests must be synchronous to clk.

Decomposition:
- Shared package/header holds:
  - the N_REQ and ID_W constants;
  - the synchronizer depth constant (SYNC_STAGES=2);
  - the encoding of the acknowledge ID, so that encoder output y and ack_id stay consistent.
- One natural sub-module: rise_edge_det, a single-channel instance containing the optional synchronizer, req_prev flop and evt output. It is instantiated N_REQ times.
- Pending, overflow and mask logic stay in the top module.

Test Plan:
- Reset with req_in=4'b0101 held high, then release rst → no events; pend=0, irq=0 and overflow=0 for 10 cycles.
- req_in[2] pulse 0→1, en_mask=4'b1111 → pend=4'b0100 and irq=1 from cycle k+1. Then ack=1, ack_id=2 → pend=4'b0000 next cycle.
- Two rising edges on req_in[3] with no ack between them → overflow=4'b1000 and pend[3]=1. Then clr_ovf → overflow=0 while pend[3] remains 1.
- Same-cycle evt[1] and ack with ack_id=1 while pending[1]=1 → pending[1] stays 1 and overflow[1] stays 0.
- en_mask=4'b0000 with events on all channels → pend=0 and irq=0. Then set en_mask=4'b1111 → pend=4'b1111 in the same cycle; the downstream encoder gives y=3, v=1.
- With IRQ_SYNC_EN defined: req_in[0] rise → pend[0]=1 exactly 3 cycles later. Assert rst mid-pending → pend=0 asynchronously.

Source files
------------

// File: rtl/irq_pending_latch_4ch_pkg.sv
// Shared constants and ack-ID encoding for irq_pending_latch_4ch.
// Optional input synchronizer selected by macro IRQ_SYNC_EN.
package irq_pending_latch_4ch_pkg;

    localparam int N_REQ       = 4;
    localparam int ID_W        = $clog2(N_REQ);
    localparam int SYNC_STAGES = 2;

    // Clocks after reset release during which edge detection is blocked
`ifdef IRQ_SYNC_EN
    localparam logic [1:0] POST_RST_CYC = 2'(SYNC_STAGES + 1);
`else
    localparam logic [1:0] POST_RST_CYC = 2'd1;
`endif

    // Channel ID as produced by the encoder (y) and returned on ack_id
    typedef logic [ID_W-1:0] ch_id_t;

    function automatic logic [N_REQ-1:0] id_onehot(input ch_id_t id);
        logic [N_REQ-1:0] one;
        one = N_REQ'(1);
        return one << id;
    endfunction

endpackage

// File: rtl/irq_pending_latch_4ch_edge.sv
// Single-channel rising-edge detector with optional input synchronizer.
// IRQ_SYNC_EN inserts SYNC_STAGES flops ahead of the edge detect.
module rise_edge_det
    import irq_pending_latch_4ch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic arm,
    output logic evt
);

    logic req_s;
    logic req_prev;

`ifdef IRQ_SYNC_EN
    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], req};
    end

    assign req_s = sync[SYNC_STAGES-1];
`else
    assign req_s = req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) req_prev <= 1'b0;
        else     req_prev <= req_s;
    end

    // arm stays low until req_prev holds a real post-reset sample
    assign evt = arm & req_s & ~req_prev;

endmodule

// File: rtl/irq_pending_latch_4ch.sv
// Latches request edges into pending flags cleared by ack, with mask,
// summary irq and sticky overflow. Optional synchronizer: IRQ_SYNC_EN.
module irq_pending_latch_4ch
    import irq_pending_latch_4ch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] en_mask,
    input  logic             ack,
    input  logic [ID_W-1:0]  ack_id,
    input  logic             clr_ovf,
    output logic [N_REQ-1:0] pend,
    output logic             irq,
    output logic [N_REQ-1:0] overflow
);

    logic [N_REQ-1:0] evt;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] ack_hit;
    logic [N_REQ-1:0] ovf_set;
    logic [1:0]       blk_cnt;
    logic             arm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            blk_cnt <= 2'd0;
        else if (!arm)
            blk_cnt <= blk_cnt + 2'd1;
    end

    assign arm = (blk_cnt == POST_RST_CYC);

    for (genvar i = 0; i < N_REQ; i++) begin : g_edge
        rise_edge_det u_det (
            .clk (clk),
            .rst (rst),
            .req (req_in[i]),
            .arm (arm),
            .evt (evt[i])
        );
    end

    assign ack_hit = ack ? id_onehot(ch_id_t'(ack_id)) : '0;
    assign ovf_set = evt & pending & ~ack_hit;

    // A new event beats a same-cycle ack so it is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            pending  <= evt | (pending & ~ack_hit);
            overflow <= (clr_ovf ? '0 : overflow) | ovf_set;
        end
    end

    assign pend = pending & en_mask;
    assign irq  = |pend;

endmodule
